buffer_dump_tx: RTL
===================

Name: buffer_dump_tx

Overview:
- Reader and transmitter for the 16-character display buffer. The UART receive path writes the buffer; this block reads it back and streams it out.
- On a start pulse it reads each buffer location in order and passes every byte to the existing UART transmitter through its start/busy handshake. Non-printable bytes are replaced, and CR/LF are optionally appended.
- Sits between the display-buffer memory (second read port, 1-cycle registered read) and the UART transmitter.

Parameters:
- DEPTH, 16, number of buffer locations dumped per request.
- ADDR_W, 4, buffer address width; DEPTH must equal 2**ADDR_W.
- APPEND_CRLF, 1, when 1, send 8'h0D then 8'h0A after the last character.
- SANITIZE, 1, when 1, bytes outside 8'h20..8'h7E are sent as 8'h2E ('.').
- ACK_TIMEOUT, 64, CLK cycles to wait for tx_busy to rise after tx_start before treating the byte as sent.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  dump request; sampled only in IDLE.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  8  buffer byte; valid the cycle after rd_en.
- tx_start  out  1  one-cycle strobe to the UART transmitter.
- tx_data  out  8  byte to transmit; held stable from tx_start until the byte completes.
- tx_busy  in  1  UART transmitter busy.
- busy  out  1  high from acceptance of start until done.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low, RST_N.
- Reset values: all outputs 0; state IDLE; index 0; timeout counter 0. Asserting RST_N low mid-dump aborts on the next edge; tx_start is never left asserted.
- FSM states: IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_DONE, TRAILER, FINISH.
  - IDLE: start=1 -> READ, busy<=1, index<=0.
  - READ: rd_en=1, rd_addr=index for exactly one cycle -> LATCH.
  - LATCH: register rd_data; if SANITIZE=1, map non-printable bytes to 8'h2E; -> SEND.
  - SEND: wait while tx_busy=1. When tx_busy=0, drive tx_start=1 for exactly one cycle with tx_data valid -> WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then -> WAIT_DONE. If ACK_TIMEOUT cycles pass first, also -> WAIT_DONE (the transmitter saw the byte while already mid-byte).
  - WAIT_DONE: wait for tx_busy=0. If index = DEPTH-1 -> TRAILER (APPEND_CRLF=1) or FINISH. Otherwise index+1 -> READ.
  - TRAILER: sends 8'h0D then 8'h0A, each through the same SEND / WAIT_ACK / WAIT_DONE sequence, then -> FINISH.
  - FINISH: done=1 for one cycle, busy<=0 -> IDLE.
- start while busy=1 is ignored; there is no queuing.
- start on the same cycle as done: the pulse is ignored. A new request is accepted one cycle after done falls.
- index is ADDR_W bits and never wraps during a dump; the terminal compare is index = DEPTH-1.
- tx_data changes only in LATCH and TRAILER, never while tx_busy=1.
- rd_addr holds its last value outside READ; consumers gate on rd_en.
- Latency:
  - start to first rd_en: 1 cycle.
  - start to first tx_start: 3 cycles when tx_busy=0.
  - Per byte: 4 cycles plus the transmitter frame time.
- If tx_busy is high when start arrives, SEND stalls until it falls; no byte is dropped.

Decomposition:
- Shared package (pmod_1414_pkg):
  - ASCII constants CR=8'h0D, LF=8'h0A, SUBST=8'h2E, PRINT_LO=8'h20, PRINT_HI=8'h7E.
  - FSM state localparams (3-bit encoding).
- One sub-module, tx_byte_handshake. It holds the SEND / WAIT_ACK / WAIT_DONE sequence and the timeout counter.
  - Interface: req/byte in; tx_start/tx_data/tx_busy to the UART; ack pulse back when the byte completes.
  - It is reused for buffer bytes and trailer bytes.
- The top-level FSM keeps only the index, the read sequencing and the trailer selection.

Test Plan:
- Buffer "HELLO WORLD     " (16 bytes), tx_busy model rises 1 cycle after tx_start and stays high 10 cycles, start pulse -> 18 tx_start pulses: 48,45,4C,4C,4F,20,57,4F,52,4C,44,20,20,20,20,20,0D,0A. Then one done pulse; busy low.
- Buffer containing 8'h07 at addr 3 and 8'h80 at addr 9, SANITIZE=1 -> bytes 3 and 9 transmitted as 8'h2E; all others unchanged.
- Second start pulse mid-dump (after byte 5) -> ignored; exactly 18 bytes total; no restart.
- tx_busy held high 20 cycles before and across start -> first tx_start only after tx_busy falls; tx_data stable throughout.
- tx_busy never rises (dead transmitter), ACK_TIMEOUT=64 -> each byte advances after 64 cycles; done asserted after 18 timeouts.
- RST_N low for 1 cycle during WAIT_DONE of byte 7 -> next cycle all outputs 0 and state IDLE. A subsequent start dumps from address 0.

Source files
------------

// File: rtl/pmod_1414_pkg.sv
// Shared constants, FSM state encoding and byte sanitising helper for the
// display-buffer dump path.
package pmod_1414_pkg;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] SUBST    = 8'h2E;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // One encoding shared by the dump sequencer and the byte handshake; each
  // block uses the subset of states that belongs to it.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_LATCH     = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_TRAILER   = 3'd6,
    S_FINISH    = 3'd7
  } state_t;

  // Replace anything outside printable ASCII with '.'.
  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return ((b < PRINT_LO) || (b > PRINT_HI)) ? SUBST : b;
  endfunction

endpackage

// File: rtl/buffer_dump_tx_if.sv
// Buffer read port plus UART transmitter handshake, as seen by the dumper.
interface buffer_dump_tx_if #(
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    output rd_en, rd_addr, tx_start, tx_data,
    input  rd_data, tx_busy
  );

  modport slave (
    input  rd_en, rd_addr, tx_start, tx_data,
    output rd_data, tx_busy
  );
endinterface

// File: rtl/buffer_dump_tx_handshake.sv
// Hands one byte to the UART transmitter: waits for the transmitter to be
// free, strobes tx_start, waits for busy to rise (or times out), then waits
// for busy to fall and pulses ack.
module tx_byte_handshake
  import pmod_1414_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] req_byte,
  output logic       ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state, state_next;
  logic [7:0]         pend;
  logic               loaded;
  logic [TIMER_W-1:0] timer;

  // State register plus byte staging and the acknowledge timeout counter.
  // tx_data is only ever reloaded at the end of a cycle where tx_busy is low,
  // so a byte in flight never sees its data change underneath it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pend    <= '0;
      tx_data <= '0;
      loaded  <= 1'b0;
      timer   <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state <= state_next;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (req) begin
            pend <= req_byte;
            if (!tx_busy) begin
              tx_data <= req_byte;
              loaded  <= 1'b1;
            end else begin
              loaded  <= 1'b0;
            end
          end
        end
        S_SEND: begin
          timer <= '0;
          if (!loaded && !tx_busy) begin
            tx_data <= pend;
            loaded  <= 1'b1;
          end
        end
        S_WAIT_ACK: timer <= timer + TIMER_W'(1);
        default:    timer <= '0;
      endcase
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    tx_start   = 1'b0;
    ack        = 1'b0;
    case (state)
      S_IDLE:     if (req) state_next = S_SEND;
      S_SEND: begin
        if (loaded && !tx_busy) begin
          tx_start   = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      // A timeout means the transmitter took the byte while already busy.
      S_WAIT_ACK: begin
        if (tx_busy || (timer == TIMER_W'(ACK_TIMEOUT - 1)))
          state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          ack        = 1'b1;
          state_next = S_IDLE;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/buffer_dump_tx.sv
// Display-buffer dumper: on start, reads every buffer location in order and
// streams it to the UART, optionally sanitising bytes and appending CR/LF.
module buffer_dump_tx
  import pmod_1414_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,   // DEPTH must equal 2**ADDR_W
  parameter bit APPEND_CRLF = 1'b1,
  parameter bit SANITIZE    = 1'b1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  buffer_dump_tx_if.master bus,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // S_SEND here means "a byte is in flight in the handshake"; the handshake
  // itself walks SEND / WAIT_ACK / WAIT_DONE.
  state_t            state, state_next;
  logic [ADDR_W-1:0] index;
  logic              in_trailer;
  logic              trailer_lf;
  logic              hs_req;
  logic [7:0]        hs_byte;
  logic              hs_ack;

  // index only changes on the way into READ, so the address holds otherwise.
  assign bus.rd_addr = index;

  tx_byte_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_handshake (
    .clk      (CLK),
    .rst_n    (RST_N),
    .req      (hs_req),
    .req_byte (hs_byte),
    .ack      (hs_ack),
    .tx_start (bus.tx_start),
    .tx_data  (bus.tx_data),
    .tx_busy  (bus.tx_busy)
  );

  // Sequencer state, buffer index, trailer tracking and the busy flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      index      <= '0;
      in_trailer <= 1'b0;
      trailer_lf <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            index      <= '0;
            in_trailer <= 1'b0;
            trailer_lf <= 1'b0;
          end
        end
        S_SEND: begin
          if (hs_ack) begin
            if (in_trailer)       trailer_lf <= 1'b1;
            else if (index != LAST) index    <= index + ADDR_W'(1);
            else if (APPEND_CRLF)  in_trailer <= 1'b1;
          end
        end
        S_FINISH: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state, read strobe, handshake request and done decode.
  always_comb begin
    state_next = state;
    bus.rd_en  = 1'b0;
    hs_req     = 1'b0;
    hs_byte    = '0;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_READ;
      S_READ: begin
        bus.rd_en  = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        hs_req     = 1'b1;
        hs_byte    = SANITIZE ? sanitize(bus.rd_data) : bus.rd_data;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (hs_ack) begin
          if (in_trailer)
            state_next = trailer_lf ? S_FINISH : S_TRAILER;
          else if (index == LAST)
            state_next = APPEND_CRLF ? S_TRAILER : S_FINISH;
          else
            state_next = S_READ;
        end
      end
      S_TRAILER: begin
        hs_req     = 1'b1;
        hs_byte    = trailer_lf ? LF : CR;
        state_next = S_SEND;
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
